// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the memory-access / writeback stage: op encodings,
// byte-lane masks, FSM states and small op-decode helpers.
package mem_writeback_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LBU  = 4'd2;
    localparam logic [3:0] MEM_LH   = 4'd3;
    localparam logic [3:0] MEM_LHU  = 4'd4;
    localparam logic [3:0] MEM_LW   = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;
    typedef enum logic {ST_IDLE, ST_BUSY} wb_state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH);
    endfunction

    function automatic mem_size_e op_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
            MEM_LW, MEM_SW:          return SZ_WORD;
            default:                 return SZ_NONE;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    return BE_BYTE0;
                    2'd1:    return BE_BYTE1;
                    2'd2:    return BE_BYTE2;
                    default: return BE_BYTE3;
                endcase
            end
            SZ_HALF: return off[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_WORD: return BE_WORD;
            default: return BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_writeback_load_extend.sv
// Selects the addressed byte/halfword lane of a little-endian read word and
// sign- or zero-extends it according to the load op. Purely combinational.
module load_extend
    import mem_writeback_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane select followed by extension; word loads pass straight through.
    always_comb begin
        byte_val = rdata[7:0];
        case (offset)
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            2'd3:    byte_val = rdata[31:24];
            default: byte_val = rdata[7:0];
        endcase
        half_val = offset[1] ? rdata[31:16] : rdata[15:0];
        ext = rdata;
        case (op_size(op))
            SZ_BYTE: ext = is_signed(op) ? {{(DATA_W-8){byte_val[7]}}, byte_val}
                                         : {{(DATA_W-8){1'b0}}, byte_val};
            SZ_HALF: ext = is_signed(op) ? {{(DATA_W-16){half_val[15]}}, half_val}
                                         : {{(DATA_W-16){1'b0}}, half_val};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Memory-access and writeback stage between EX/MEM and the register file.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no access outstanding; ALU results written back directly
//   ST_BUSY | request on the memory port, waiting for mem_ack
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [3:0]            in_memOp,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_storeData,
    input  logic [DATA_W-1:0]     in_aluResult,
    input  logic [REG_ADDR_W-1:0] in_regDest,
    input  logic                  in_regWriteEnable,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_byteEnable,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  wb_writeEnable,
    output logic [REG_ADDR_W-1:0] wb_writeAddr,
    output logic [DATA_W-1:0]     wb_writeResult,
    output logic                  stall,
    output logic                  misaligned
);

    wb_state_e             state, state_next;
    logic [3:0]            op_q, op_next;
    logic [1:0]            off_q, off_next;
    logic [REG_ADDR_W-1:0] dest_q, dest_next;
    logic                  rwe_q, rwe_next;

    logic                  mem_req_next, mem_we_next;
    logic [ADDR_W-1:0]     mem_addr_next;
    logic [DATA_W-1:0]     mem_wdata_next;
    logic [3:0]            be_next;
    logic                  wb_we_next;
    logic [REG_ADDR_W-1:0] wb_addr_next;
    logic [DATA_W-1:0]     wb_result_next;
    logic                  misaligned_next;

    logic [1:0]            off_in;
    mem_size_e             size_in;
    logic                  is_mem_op, start_access;
    logic [DATA_W-1:0]     load_word;

    assign off_in       = in_addr[1:0];
    assign size_in      = op_size(in_memOp);
    assign is_mem_op    = is_load(in_memOp) || is_store(in_memOp);
    assign start_access = (state == ST_IDLE) && in_valid && is_mem_op &&
                          !is_misaligned(in_memOp, off_in);

    // Hold upstream while an access is being launched or is still waiting.
    assign stall = (state == ST_BUSY) ? !mem_ack : start_access;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata  (mem_rdata),
        .offset (off_q),
        .op     (op_q),
        .ext    (load_word)
    );

    // Next-state and next-output decode; mem address/data hold between accesses.
    always_comb begin
        state_next      = state;
        op_next         = op_q;
        off_next        = off_q;
        dest_next       = dest_q;
        rwe_next        = rwe_q;
        mem_req_next    = mem_req;
        mem_we_next     = mem_we;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        be_next         = mem_byteEnable;
        wb_we_next      = 1'b0;
        wb_addr_next    = wb_writeAddr;
        wb_result_next  = wb_writeResult;
        misaligned_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && !is_mem_op) begin
                    wb_we_next     = in_regWriteEnable && (in_regDest != REG_ZERO);
                    wb_addr_next   = in_regDest;
                    wb_result_next = in_aluResult;
                end else if (in_valid && !start_access) begin
                    misaligned_next = 1'b1;
                end else if (start_access) begin
                    state_next    = ST_BUSY;
                    mem_req_next  = 1'b1;
                    mem_we_next   = is_store(in_memOp);
                    mem_addr_next = {in_addr[ADDR_W-1:2], 2'b00};
                    be_next       = lane_mask(size_in, off_in);
                    case (size_in)
                        SZ_BYTE: mem_wdata_next = {(DATA_W/8){in_storeData[7:0]}};
                        SZ_HALF: mem_wdata_next = {(DATA_W/16){in_storeData[15:0]}};
                        default: mem_wdata_next = in_storeData;
                    endcase
                    op_next   = in_memOp;
                    off_next  = off_in;
                    dest_next = in_regDest;
                    rwe_next  = in_regWriteEnable;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_next   = ST_IDLE;
                    mem_req_next = 1'b0;
                    be_next      = BE_NONE;
                    if (is_load(op_q)) begin
                        wb_we_next     = rwe_q && (dest_q != REG_ZERO);
                        wb_addr_next   = dest_q;
                        wb_result_next = load_word;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= MEM_NONE;
            off_q          <= 2'b00;
            dest_q         <= REG_ZERO;
            rwe_q          <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= ZERO_WORD;
            mem_byteEnable <= BE_NONE;
            wb_writeEnable <= 1'b0;
            wb_writeAddr   <= REG_ZERO;
            wb_writeResult <= ZERO_WORD;
            misaligned     <= 1'b0;
        end else begin
            state          <= state_next;
            op_q           <= op_next;
            off_q          <= off_next;
            dest_q         <= dest_next;
            rwe_q          <= rwe_next;
            mem_req        <= mem_req_next;
            mem_we         <= mem_we_next;
            mem_addr       <= mem_addr_next;
            mem_wdata      <= mem_wdata_next;
            mem_byteEnable <= be_next;
            wb_writeEnable <= wb_we_next;
            wb_writeAddr   <= wb_addr_next;
            wb_writeResult <= wb_result_next;
            misaligned     <= misaligned_next;
        end
    end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Memory-access and writeback stage; sits between the EX/MEM pipeline register and the register file write port.
- Executes MIPS loads/stores against data memory over a req/ack handshake.
- Aligns and extends load data; drives the register file's single write port (enable, address, result).
- Raises a pipeline stall while a memory access is outstanding.

Parameters:
- DATA_W, 32, data and word width
- ADDR_W, 32, byte-address width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  EX/MEM holds a live instruction
- in_memOp  in  4  MEM_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW
- in_addr  in  ADDR_W  effective byte address
- in_storeData  in  DATA_W  rt value for stores
- in_aluResult  in  DATA_W  result for non-memory instructions
- in_regDest  in  REG_ADDR_W  destination register
- in_regWriteEnable  in  1  instruction writes a register
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address ({in_addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_byteEnable  out  4  active byte lanes
- mem_ack  in  1  request completes this cycle
- mem_rdata  in  DATA_W  read word, valid with mem_ack
- wb_writeEnable  out  1  register file write enable
- wb_writeAddr  out  REG_ADDR_W  register file write address
- wb_writeResult  out  DATA_W  register file write data
- stall  out  1  hold IF/ID/EX and EX/MEM
- misaligned  out  1  one-cycle address-error pulse

Behaviour:
- Reset:
  - State IDLE.
  - mem_req, mem_we, mem_byteEnable, wb_writeEnable and misaligned are 0.
  - wb_writeAddr and wb_writeResult are 0.
  - Any outstanding access is abandoned; a late mem_ack is ignored.
- States: IDLE and BUSY. All wb_* and mem_* outputs and misaligned are registered. stall is combinational.
- IDLE, in_valid with a non-memory op:
  - At the next edge, wb_writeEnable = in_regWriteEnable & (in_regDest != 0).
  - wb_writeAddr = in_regDest; wb_writeResult = in_aluResult.
  - Latency 1; stall stays 0.
- IDLE, in_valid with an aligned memory op:
  - stall = 1 in that cycle.
  - At the next edge: state BUSY, mem_req = 1, mem_addr/mem_we/mem_byteEnable/mem_wdata are set, and the dest, op and offset are latched.
- Byte lanes are little-endian; off = in_addr[1:0].
  - Byte ops: byteEnable = 1<<off.
  - Halfword ops: 0011 or 1100.
  - Word ops: 1111.
  - mem_wdata replicates the byte or halfword across all lanes.
- BUSY:
  - mem_req and address stay stable until mem_ack.
  - stall = ~mem_ack.
  - On mem_ack the next edge clears mem_req and mem_byteEnable and returns to IDLE.
  - Load: on the same edge wb_* is written with the extended data.
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - Lane selected by the latched offset.
  - Store: wb_writeEnable = 0.
- Load-to-writeback latency = 1 + (cycles until ack); minimum 2.
- Inputs stay held while stall = 1; the upstream stage owns that requirement. With stall = 0 in the ack cycle, the next instruction is presented one edge later.
- Misalignment:
  - Halfword ops with in_addr[0] = 1, or word ops with in_addr[1:0] != 0.
  - No memory request and no register write.
  - misaligned pulses 1 for one cycle; stall stays 0.
- wb_writeEnable deasserts after one cycle unless a new writeback occurs.
- in_valid = 0: wb_writeEnable = 0 at the next edge.
- Destination register 0: never asserts wb_writeEnable.

Decomposition:
- Shared package:
  - MEM_* op encodings (4-bit).
  - Byte-enable constants (BE_BYTE0..3, BE_HALF_LO/HI, BE_WORD).
  - isLoad/isStore/isSigned and size-decode functions.
  - ZERO_WORD and REG_ZERO constants.
- One combinational sub-module, load_extend: inputs rdata, offset, op; output extended word. It is reusable by a future cache.

Test Plan:
- ALU op, in_aluResult = 0x12345678, dest 5 -> next cycle wb_writeEnable = 1, wb_writeAddr = 5, wb_writeResult = 0x12345678; stall never high.
- LW addr 0x100, ack two cycles after mem_req, rdata 0xDEADBEEF:
  - mem_addr = 0x100, byteEnable = 1111.
  - stall high for 3 cycles.
  - wb_writeResult = 0xDEADBEEF the cycle after ack.
- LB addr 0x203, rdata 0x80FF0000 -> mem_addr 0x200, byteEnable 1000, wb_writeResult 0xFFFFFF80. Same with LBU -> 0x00000080.
- SH addr 0x302, data 0x0000ABCD -> mem_we = 1, byteEnable 1100, mem_wdata 0xABCDABCD, no register write.
- LW addr 0x101 -> misaligned pulse 1 cycle, mem_req stays 0, wb_writeEnable 0; dest 0 on an ALU op -> wb_writeEnable 0.
- rst asserted while BUSY awaiting ack:
  - Next cycle mem_req = 0, stall = 0, wb_writeEnable = 0.
  - A subsequent stray mem_ack causes no write.
